// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load-value sanitizer.
// Used by bcd_digit and bcd_counter_n. There is no latency and no flow control.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // A nibble outside 0..9 is forced to zero so q can never hold a non-BCD digit.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_ZERO : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple incrementer/decrementer.
// Purely combinational with no latency. It has no flow control; cin acts as the enable.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       cin,
  input  logic       up,
  output bcd_digit_t d_next,
  output logic       cout
);

  always_comb begin
    d_next = d;
    cout   = 1'b0;
    if (cin) begin
      if (up) begin
        if (d == BCD_MAX) begin
          d_next = BCD_ZERO;
          cout   = 1'b1;
        end else begin
          d_next = d + 4'd1;
        end
      end else begin
        if (d == BCD_ZERO) begin
          d_next = BCD_MAX;
          cout   = 1'b1;
        end else begin
          d_next = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down event counter with parallel load and a one-cycle wrap pulse on carry.
// q updates 1 edge after x rises, or 3 edges when BCD_COUNTER_SYNC_EN is defined. There is no backpressure.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                x,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] q,
  output logic                carry
);

  logic                xs;
  logic                x_d;
  logic                ev;
  logic [DIGITS:0]     c;
  logic [4*DIGITS-1:0] q_next;
  logic [4*DIGITS-1:0] din_clean;
  logic                carry_next;

`ifdef BCD_COUNTER_SYNC_EN
  logic [1:0] x_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) x_sync <= 2'b00;
    else        x_sync <= {x_sync[0], x};
  end

  assign xs = x_sync[1];
`else
  assign xs = x;
`endif

  // History resets high so an x already high at reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) x_d <= 1'b1;
    else        x_d <= xs;
  end

  assign ev   = xs & ~x_d;
  assign c[0] = ev;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .d      (q[4*g +: 4]),
      .cin    (c[g]),
      .up     (up),
      .d_next (q_next[4*g +: 4]),
      .cout   (c[g+1])
    );
    assign din_clean[4*g +: 4] = bcd_sanitize(din[4*g +: 4]);
  end

  assign carry_next = c[DIGITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      carry <= 1'b0;
    end else if (load) begin
      q     <= din_clean;
      carry <= 1'b0;
    end else if (ev) begin
      q     <= q_next;
      carry <= carry_next;
    end else begin
      carry <= 1'b0;
    end
  end

endmodule
